// File: rtl/capture_reader.sv
// Capture readback engine: fetches stored samples from SDRAM one read at a time
// and streams them in capture order through a small prefetch FIFO.
module capture_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [12:0] ADDR_BASE  = 13'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [8:0]  sample_count_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        sdram_rd_req_o,
    output logic [12:0] sdram_rd_addr_o,
    input  logic        sdram_rd_ready_i,
    input  logic        sdram_rd_valid_i,
    input  logic [7:0]  sdram_rd_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_data_o,
    output logic [8:0]  out_idx_o,
    output logic        out_last_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENT_W = 18;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   DEPTH_L = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DATA,
        S_FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [8:0]       count_q, count_d;
    logic [8:0]       rd_idx_q, rd_idx_d;
    logic             req_q, req_d;
    logic [12:0]      addr_q, addr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fill_q, fill_d;
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic             clr;
    logic             accept;
    logic             full;
    logic             empty;
    logic [ENT_W-1:0] push_ent;
    logic [ENT_W-1:0] head;

    assign full   = (fill_q == DEPTH_L);
    assign empty  = (fill_q == '0);
    assign head   = mem_q[rd_ptr_q];
    assign accept = req_q && sdram_rd_ready_i;
    assign pop    = !empty && out_ready_i;

    // rd_idx has already advanced on accept, so the returning byte is rd_idx-1
    assign push_ent = {sdram_rd_data_i, rd_idx_q - 9'd1, (rd_idx_q == count_q)};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        req_d    = req_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = done_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        push     = 1'b0;
        clr      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !busy_q) begin
                    count_d  = sample_count_i;
                    rd_idx_d = '0;
                    clr      = 1'b1;
                    done_d   = (sample_count_i == 9'd0);
                    if (sample_count_i != 9'd0) begin
                        state_d = S_ISSUE;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!req_q && !full) begin
                    req_d  = 1'b1;
                    addr_d = ADDR_BASE + {4'b0000, rd_idx_q};
                end else if (accept) begin
                    req_d    = 1'b0;
                    rd_idx_d = rd_idx_q + 9'd1;
                    state_d  = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (sdram_rd_valid_i) begin
                    push    = 1'b1;
                    state_d = (rd_idx_q == count_q) ? S_IDLE : S_ISSUE;
                end
            end
            S_FLUSH: begin
                if (sdram_rd_valid_i) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase

        if (pop && head[0] && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        // A read already handed to the controller must be drained before idle
        if (abort_i) begin
            clr    = 1'b1;
            push   = 1'b0;
            req_d  = 1'b0;
            done_d = 1'b0;
            if (((state_q == S_WAIT_DATA) && !sdram_rd_valid_i) ||
                ((state_q == S_FLUSH) && !sdram_rd_valid_i) ||
                ((state_q == S_ISSUE) && accept)) begin
                state_d = S_FLUSH;
                busy_d  = 1'b1;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        end

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                fill_d = fill_q + CNT_ONE;
            end else if (pop && !push) begin
                fill_d = fill_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rd_idx_q <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign sdram_rd_req_o  = req_q;
    assign sdram_rd_addr_o = addr_q;
    assign out_valid_o     = !empty;
    assign out_data_o      = empty ? 8'd0 : head[17:10];
    assign out_idx_o       = empty ? 9'd0 : head[9:1];
    assign out_last_o      = empty ? 1'b0 : head[0];

endmodule

// File: tb/tb_capture_reader.sv
// Bench for capture_reader: SDRAM responder, random consumer and a
// queue-based model of the expected sample stream.
module tb_capture_reader;

    localparam int          DEPTH = 4;
    localparam logic [12:0] BASE  = 13'd8100;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [8:0]  sample_count;
    logic        busy;
    logic        done;
    logic        sdram_rd_req;
    logic [12:0] sdram_rd_addr;
    logic        sdram_rd_ready;
    logic        sdram_rd_valid;
    logic [7:0]  sdram_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [8:0]  out_idx;
    logic        out_last;

    capture_reader #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_BASE (BASE)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .abort_i         (abort),
        .sample_count_i  (sample_count),
        .busy_o          (busy),
        .done_o          (done),
        .sdram_rd_req_o  (sdram_rd_req),
        .sdram_rd_addr_o (sdram_rd_addr),
        .sdram_rd_ready_i(sdram_rd_ready),
        .sdram_rd_valid_i(sdram_rd_valid),
        .sdram_rd_data_i (sdram_rd_data),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .out_idx_o       (out_idx),
        .out_last_o      (out_last)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  mem [8192];
    logic [17:0] beats[$];
    logic [12:0] acc_addrs[$];

    int ready_pct = 100;
    bit ready_low = 1'b0;
    int out_pct   = 100;
    int lat_min   = 3;
    int lat_max   = 3;

    int returned, popped, occ_prev, req_rises, ov_seen;
    int full_viol, stab_viol, extra_out;
    bit req_prev, hold_prev, pend;
    int pend_cnt;
    logic [12:0] pend_addr;
    logic [17:0] hold_val;

    // SDRAM controller and consumer model; all inputs change on negedge
    always @(negedge clk) begin : mon
        int  occ_cur;
        bit  rdy;
        bit  ordy;
        occ_cur = returned - popped;
        if (sdram_rd_req && !req_prev) begin
            req_rises++;
            if (occ_prev >= DEPTH) full_viol++;
        end
        if (hold_prev) begin
            if (!out_valid || {out_data, out_idx, out_last} !== hold_val)
                stab_viol++;
        end
        if (out_valid) ov_seen++;
        req_prev = sdram_rd_req;
        occ_prev = occ_cur;

        sdram_rd_valid = 1'b0;
        sdram_rd_data  = 8'h00;
        if (pend) begin
            if (pend_cnt <= 1) begin
                sdram_rd_valid = 1'b1;
                sdram_rd_data  = mem[pend_addr];
                pend = 1'b0;
                returned++;
            end else begin
                pend_cnt--;
            end
        end

        rdy = ready_low ? 1'b0 : ($urandom_range(99) < ready_pct);
        sdram_rd_ready = rdy;
        if (sdram_rd_req && rdy) begin
            if (pend) extra_out++;
            acc_addrs.push_back(sdram_rd_addr);
            pend      = 1'b1;
            pend_cnt  = $urandom_range(lat_max, lat_min);
            pend_addr = sdram_rd_addr;
        end

        ordy = ($urandom_range(99) < out_pct);
        out_ready = ordy;
        if (out_valid && ordy) begin
            beats.push_back({out_data, out_idx, out_last});
            popped++;
        end
        hold_prev = out_valid && !ordy;
        hold_val  = {out_data, out_idx, out_last};
    end

    task automatic clear_log();
        @(posedge clk);
        #1;
        beats.delete();
        acc_addrs.delete();
        returned  = 0;
        popped    = 0;
        occ_prev  = 0;
        req_rises = 0;
        ov_seen   = 0;
        full_viol = 0;
        stab_viol = 0;
        extra_out = 0;
    endtask

    task automatic fill_random_mem();
        for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        sample_count = 9'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stream(input string name, input int n);
        logic [17:0] exp;
        vectors++;
        if (beats.size() != n) begin
            errors++;
            $display("FAIL %s beat count: got %0d expected %0d", name, beats.size(), n);
        end
        for (int i = 0; i < n && i < beats.size(); i++) begin
            exp = {mem[(int'(BASE) + i) % 8192], 9'(i), (i == n - 1)};
            vectors++;
            if (beats[i] !== exp) begin
                errors++;
                $display("FAIL %s beat %0d: got %h expected %h", name, i, beats[i], exp);
            end
        end
        vectors++;
        if (acc_addrs.size() != n || req_rises != n) begin
            errors++;
            $display("FAIL %s reads: got %0d accepts %0d reqs expected %0d",
                     name, acc_addrs.size(), req_rises, n);
        end
        for (int i = 0; i < n && i < acc_addrs.size(); i++) begin
            vectors++;
            if (acc_addrs[i] !== 13'((int'(BASE) + i) % 8192)) begin
                errors++;
                $display("FAIL %s addr %0d: got %0d expected %0d", name, i,
                         acc_addrs[i], (int'(BASE) + i) % 8192);
            end
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end flags: got done=%b busy=%b expected done=1 busy=0",
                     name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, sdram_rd_req, sdram_rd_addr, out_valid, out_idx, out_last, out_data} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b req=%b addr=%0d ov=%b idx=%0d last=%b data=%h expected all 0",
                     busy, done, sdram_rd_req, sdram_rd_addr, out_valid, out_idx, out_last, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        clear_log();
        for (int i = 0; i < 5; i++) mem[(int'(BASE) + i) % 8192] = 8'(8'hA0 + i);
        lat_min = 3; lat_max = 3; out_pct = 100; ready_pct = 100;
        start_run(5);
        wait_done(300, to);
        vectors++;
        if (to) begin errors++; $display("FAIL basic done timeout: got done=%b expected 1", done); end
        check_stream("basic", 5);
    endtask

    task automatic test_backpressure();
        bit to;
        fill_random_mem();
        clear_log();
        lat_min = 1; lat_max = 5; out_pct = 30; ready_pct = 60;
        start_run(266);
        wait_done(20000, to);
        vectors++;
        if (to) begin errors++; $display("FAIL bp done timeout: got done=%b expected 1", done); end
        check_stream("bp", 266);
        vectors++;
        if (full_viol != 0 || extra_out != 0) begin
            errors++;
            $display("FAIL bp req while full: got %0d (outstanding %0d) expected 0", full_viol, extra_out);
        end
        vectors++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL bp output hold: got %0d changes expected 0", stab_viol);
        end
        out_pct = 100; ready_pct = 100;
    endtask

    task automatic test_ready_stall();
        bit to;
        bit seen;
        logic [12:0] a0;
        fill_random_mem();
        clear_log();
        lat_min = 2; lat_max = 2;
        ready_low = 1'b1;
        start_run(3);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = sdram_rd_req;
        end
        vectors++;
        if (!seen) begin errors++; $display("FAIL stall req: got 0 expected 1"); end
        a0 = sdram_rd_addr;
        vectors++;
        if (a0 !== BASE) begin errors++; $display("FAIL stall first addr: got %0d expected %0d", a0, BASE); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (sdram_rd_req !== 1'b1 || sdram_rd_addr !== a0) begin
                errors++;
                $display("FAIL stall hold %0d: got req=%b addr=%0d expected req=1 addr=%0d",
                         c, sdram_rd_req, sdram_rd_addr, a0);
            end
        end
        ready_low = 1'b0;
        wait_done(300, to);
        vectors++;
        if (to) begin errors++; $display("FAIL stall done timeout: got done=%b expected 1", done); end
        check_stream("stall", 3);
    endtask

    task automatic test_abort();
        bit to;
        bit seen;
        fill_random_mem();
        clear_log();
        lat_min = 8; lat_max = 8;
        start_run(10);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = (acc_addrs.size() >= 1);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (!seen || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort flush: got accepted=%b busy=%b ov=%b expected 1 1 0", seen, busy, out_valid);
        end
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = (busy === 1'b0);
            if (!seen && returned != 0 && c > 2) break;
        end
        vectors++;
        if (!seen || returned != 1) begin
            errors++;
            $display("FAIL abort busy release: got idle=%b returned=%0d expected 1 1", seen, returned);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (ov_seen != 0 || beats.size() != 0 || done !== 1'b0 || req_rises != 1) begin
            errors++;
            $display("FAIL abort discard: got ov=%0d beats=%0d done=%b reqs=%0d expected 0 0 0 1",
                     ov_seen, beats.size(), done, req_rises);
        end
        clear_log();
        lat_min = 2; lat_max = 2;
        start_run(4);
        wait_done(300, to);
        vectors++;
        if (to) begin errors++; $display("FAIL abort restart timeout: got done=%b expected 1", done); end
        check_stream("abort restart", 4);
    endtask

    task automatic test_zero_count();
        bit to;
        clear_log();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero pre done: got %b expected 0", done); end
        start_run(0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero done: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (req_rises != 0 || acc_addrs.size() != 0) begin
            errors++;
            $display("FAIL zero reqs: got %0d expected 0", req_rises);
        end
        fill_random_mem();
        clear_log();
        lat_min = 3; lat_max = 3;
        start_run(6);
        repeat (5) @(negedge clk);
        start_run(2);
        wait_done(400, to);
        vectors++;
        if (to) begin errors++; $display("FAIL busy start timeout: got done=%b expected 1", done); end
        check_stream("busy start", 6);
    endtask

    task automatic test_back_to_back();
        bit to;
        fill_random_mem();
        clear_log();
        lat_min = 1; lat_max = 1;
        start_run(3);
        wait_done(300, to);
        vectors++;
        if (to) begin errors++; $display("FAIL b2b first timeout: got done=%b expected 1", done); end
        clear_log();
        start_run(7);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b restart flags: got done=%b busy=%b expected 0 1", done, busy);
        end
        wait_done(400, to);
        vectors++;
        if (to) begin errors++; $display("FAIL b2b second timeout: got done=%b expected 1", done); end
        check_stream("b2b", 7);
    endtask

    task automatic test_reset_mid();
        bit to;
        fill_random_mem();
        clear_log();
        lat_min = 2; lat_max = 2; out_pct = 0;
        start_run(20);
        repeat (30) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst pre: got ov=%b busy=%b expected 1 1", out_valid, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, sdram_rd_req, sdram_rd_addr, out_valid, out_idx, out_last, out_data} !== '0) begin
            errors++;
            $display("FAIL midrst outputs: got busy=%b done=%b req=%b addr=%0d ov=%b idx=%0d last=%b data=%h expected all 0",
                     busy, done, sdram_rd_req, sdram_rd_addr, out_valid, out_idx, out_last, out_data);
        end
        rst = 1'b0;
        out_pct = 100;
        clear_log();
        repeat (20) @(negedge clk);
        vectors++;
        if (ov_seen != 0 || req_rises != 0) begin
            errors++;
            $display("FAIL midrst idle: got ov=%0d reqs=%0d expected 0 0", ov_seen, req_rises);
        end
        clear_log();
        start_run(3);
        wait_done(300, to);
        vectors++;
        if (to) begin errors++; $display("FAIL midrst restart timeout: got done=%b expected 1", done); end
        check_stream("midrst restart", 3);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        sample_count   = '0;
        sdram_rd_ready = 1'b0;
        sdram_rd_valid = 1'b0;
        sdram_rd_data  = '0;
        out_ready      = 1'b0;
        pend           = 1'b0;
        req_prev       = 1'b0;
        hold_prev      = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ready_stall();
        test_abort();
        test_zero_count();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish before 3 ms");
        $fatal(1);
    end

endmodule
